// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the instruction prefetch path
// Purpose: word/address widths, the NOP encoding, the prefetch FSM state type and
//          the queue entry type (instruction word plus its PC).
// Ports:   none (package).
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int IADDR_W = 12;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [IADDR_W-1:0] pc;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - small register queue of prefetched instruction entries
// Purpose: DEPTH-entry FIFO of pf_entry_t with synchronous clear. The head entry
//          is read straight from storage, so it is a registered output.
// Ports:   clk, rst        clock, async active-high reset
//          push, pushEntry write one entry
//          pop             remove head (ignored when empty)
//          clear           drop all entries; overrides push and pop
//          headEntry       current head entry (meaningless when level==0)
//          level           current occupancy, 0..DEPTH
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  pf_entry_t                  pushEntry,
  input  logic                       pop,
  input  logic                       clear,
  output pf_entry_t                  headEntry,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  pf_entry_t         mem [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [LW-1:0]     count;
  logic              doPop;
  logic              doPush;
  logic              full;

  assign full      = (count == LW'(DEPTH));
  assign doPop     = pop && (count != '0) && !clear;
  assign doPush    = push && !clear;
  assign headEntry = mem[rdPtr];
  assign level     = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // The issue rule upstream guarantees a free slot for every returning word.
      assert (!(doPush && full && !doPop));
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      if (doPush && !doPop)      count <= count + LW'(1);
      else if (doPop && !doPush) count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetcher between ROM and Fetch
// Purpose: issues ROM reads ahead of consumption, queues returned words with their
//          PCs and hands them to the pipeline with valid/ready. A redirect flushes
//          the queue, drops any in-flight word and restarts fetch at redirectPc.
// Ports:   clk, rst              clock, async active-high reset
//          romAddress, romRdEn   ROM read request (address sampled on the same edge)
//          romData               ROM word, valid the cycle after the sampling edge
//          redirectEn/Pc         pipeline PC write: flush and refetch at target
//          instrReady            pipeline accepts head entry
//          instrValid/Out/Pc     head entry; NOP and PC 0 when not valid
//          queueLevel            current queue occupancy
//          flushCount, starveCycles   saturating counters, only with PREFETCH_STATS_EN
// Config:  `define PREFETCH_STATS_EN to add the statistics counters and ports.
module instr_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [IADDR_W-1:0] RESET_PC = 12'h000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IADDR_W-1:0]         romAddress,
  output logic                       romRdEn,
  input  logic [INSTR_W-1:0]         romData,
  input  logic                       redirectEn,
  input  logic [IADDR_W-1:0]         redirectPc,
  input  logic                       instrReady,
  output logic                       instrValid,
  output logic [INSTR_W-1:0]         instrOut,
  output logic [IADDR_W-1:0]         instrPc,
`ifdef PREFETCH_STATS_EN
  output logic [15:0]                flushCount,
  output logic [15:0]                starveCycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0] queueLevel
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW:0] DEPTH_L = (LW + 1)'(DEPTH);

  pf_state_e          state;
  pf_state_e          stateNext;
  logic [IADDR_W-1:0] fetchPc;
  logic               inflight;
  logic [IADDR_W-1:0] inflightPc;
  logic [LW:0]        occupancy;
  logic               issue;
  logic               popHead;
  logic [LW-1:0]      level;
  pf_entry_t          headEntry;
  pf_entry_t          pushEntry;

  // At most one read is outstanding, so queue slots plus that read bound the
  // occupancy. Pops in the current cycle are deliberately not credited.
  assign occupancy = {1'b0, level} + {{LW{1'b0}}, inflight};
  assign issue     = (state == RUN) && !redirectEn && (occupancy < DEPTH_L);
  assign romRdEn   = issue;
  assign romAddress = fetchPc;

  always_comb begin
    stateNext = state;
    case (state)
      BOOT:    stateNext = RUN;
      RUN:     if (redirectEn) stateNext = FLUSH;
      FLUSH:   stateNext = redirectEn ? FLUSH : RUN;
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else begin
      state    <= stateNext;
      // issue is never set while redirectEn is high, so the only word that can
      // be in flight on a redirect edge is the one the clear below discards.
      inflight <= issue;
      if (redirectEn)  fetchPc <= redirectPc;
      else if (issue)  fetchPc <= fetchPc + IADDR_W'(1);
      if (issue) inflightPc <= fetchPc;
    end
  end

  assign pushEntry = '{instr: romData, pc: inflightPc};
  assign popHead   = instrValid && instrReady && !redirectEn;

  prefetch_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pushEntry (pushEntry),
    .pop       (popHead),
    .clear     (redirectEn),
    .headEntry (headEntry),
    .level     (level)
  );

  assign queueLevel = level;
  assign instrValid = (level != '0);
  assign instrOut   = instrValid ? headEntry.instr : NOP;
  assign instrPc    = instrValid ? headEntry.pc : '0;

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushCount   <= '0;
      starveCycles <= '0;
    end else begin
      if (redirectEn && (flushCount != 16'hFFFF)) flushCount <= flushCount + 16'd1;
      if ((state == RUN) && !instrValid && (starveCycles != 16'hFFFF))
        starveCycles <= starveCycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic [11:0] romAddress;
  logic        romRdEn;
  logic [31:0] romData;
  logic        redirectEn;
  logic [11:0] redirectPc;
  logic        instrReady;
  logic        instrValid;
  logic [31:0] instrOut;
  logic [11:0] instrPc;
  logic [2:0]  queueLevel;
`ifdef PREFETCH_STATS_EN
  logic [15:0] flushCount;
  logic [15:0] starveCycles;
`endif

  int totalChecks = 0;
  int badChecks   = 0;
  int popCount    = 0;
  logic [11:0] expQ[$];

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .romAddress  (romAddress),
    .romRdEn     (romRdEn),
    .romData     (romData),
    .redirectEn  (redirectEn),
    .redirectPc  (redirectPc),
    .instrReady  (instrReady),
    .instrValid  (instrValid),
    .instrOut    (instrOut),
    .instrPc     (instrPc),
`ifdef PREFETCH_STATS_EN
    .flushCount  (flushCount),
    .starveCycles(starveCycles),
`endif
    .queueLevel  (queueLevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: ROM[i] = i + 100.
  always @(posedge clk) begin
    if (romRdEn) romData <= 32'(romAddress) + 32'd100;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic loadExpect(input logic [11:0] start, input int n);
    logic [11:0] pc;
    expQ.delete();
    pc = start;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(pc);
      pc = pc + 12'd1;
    end
  endtask

  // Scoreboard: every accepted head entry must be the next expected PC/word.
  always @(negedge clk) begin
    if (!rst) begin
      checkVal("levelBound", 32'(queueLevel <= 3'd4), 32'd1);
      if (!instrValid) begin
        checkVal("idleInstr", instrOut, 32'h0);
        checkVal("idlePc", 32'(instrPc), 32'h0);
      end else if (instrReady && !redirectEn) begin
        popCount++;
        if (expQ.size() == 0) begin
          checkVal("extraPop", 32'(instrPc), 32'hFFFF_FFFF);
        end else begin
          logic [11:0] e;
          e = expQ.pop_front();
          checkVal("popPc", 32'(instrPc), 32'(e));
          checkVal("popInstr", instrOut, 32'(e) + 32'd100);
        end
      end
    end
  end

  task automatic waitValid(input string tag, input logic [11:0] expPc);
    int n;
    n = 0;
    @(negedge clk);
    while (!instrValid && n < 12) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, "Timeout"}, 32'(instrValid), 32'd1);
    checkVal({tag, "FirstPc"}, 32'(instrPc), 32'(expPc));
  endtask

  // Redirect timing: flush, issue target, push, valid three cycles after E0.
  task automatic checkRedirectTiming(input string tag, input logic [11:0] target);
    @(negedge clk);
    checkVal({tag, "E0valid"}, 32'(instrValid), 32'd0);
    checkVal({tag, "E0rdEn"}, 32'(romRdEn), 32'd0);
    @(negedge clk);
    checkVal({tag, "E1valid"}, 32'(instrValid), 32'd0);
    checkVal({tag, "E1rdEn"}, 32'(romRdEn), 32'd1);
    checkVal({tag, "E1addr"}, 32'(romAddress), 32'(target));
    @(negedge clk);
    checkVal({tag, "E2valid"}, 32'(instrValid), 32'd0);
    @(negedge clk);
    checkVal({tag, "E3valid"}, 32'(instrValid), 32'd1);
    checkVal({tag, "E3pc"}, 32'(instrPc), 32'(target));
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    redirectEn = 1'b0;
    redirectPc = 12'h000;
    instrReady = 1'b1;
    loadExpect(12'h000, 200);
    repeat (3) @(posedge clk);
    #1;
    checkVal("rstRdEn", 32'(romRdEn), 32'd0);
    checkVal("rstValid", 32'(instrValid), 32'd0);
    checkVal("rstLevel", 32'(queueLevel), 32'd0);
    checkVal("rstAddr", 32'(romAddress), 32'h000);
    checkVal("rstInstr", instrOut, 32'h0);

    // Test 1: reset release, streaming at full rate.
    rst = 1'b0;
    @(negedge clk);
    checkVal("bootRdEn", 32'(romRdEn), 32'd0);
    @(negedge clk);
    checkVal("firstRdEn", 32'(romRdEn), 32'd1);
    checkVal("firstAddr", 32'(romAddress), 32'h000);
    @(negedge clk);
    checkVal("secondAddr", 32'(romAddress), 32'h001);
    checkVal("notYetValid", 32'(instrValid), 32'd0);
    @(negedge clk);
    checkVal("firstValid", 32'(instrValid), 32'd1);
    checkVal("firstPc", 32'(instrPc), 32'h000);
    repeat (3) @(posedge clk);
    #2 c0 = popCount;
    repeat (10) @(posedge clk);
    #2 checkVal("throughput", 32'(popCount - c0), 32'd10);

    // Test 2: back-pressure fills the queue, then resumes without loss.
    @(posedge clk);
    #1 instrReady = 1'b0;
    repeat (10) @(negedge clk);
    checkVal("fullLevel", 32'(queueLevel), 32'd4);
    checkVal("fullRdEn", 32'(romRdEn), 32'd0);
    @(posedge clk);
    #1 instrReady = 1'b1;
    repeat (12) @(posedge clk);

    // Test 3: redirect with a read in flight.
    #1;
    checkVal("inflightBefore", 32'(romRdEn), 32'd1);
    redirectEn = 1'b1;
    redirectPc = 12'h080;
    loadExpect(12'h080, 100);
    @(posedge clk);
    #1 redirectEn = 1'b0;
    checkRedirectTiming("redir080", 12'h080);
    repeat (8) @(posedge clk);

    // Test 4: back-to-back redirects, latest target wins.
    #1;
    redirectEn = 1'b1;
    redirectPc = 12'h040;
    expQ.delete();
    @(posedge clk);
    #1;
    redirectPc = 12'h0C0;
    loadExpect(12'h0C0, 100);
    @(posedge clk);
    #1 redirectEn = 1'b0;
    checkRedirectTiming("redir0C0", 12'h0C0);
`ifdef PREFETCH_STATS_EN
    checkVal("flushCount", 32'(flushCount), 32'd3);
`endif
    repeat (8) @(posedge clk);

    // Test 5: address wrap at the top of the ROM.
    #1;
    redirectEn = 1'b1;
    redirectPc = 12'hFFE;
    loadExpect(12'hFFE, 100);
    @(posedge clk);
    #1 redirectEn = 1'b0;
    waitValid("wrap", 12'hFFE);
    repeat (8) @(posedge clk);
    #1 checkVal("wrapConsumed", 32'(expQ.size() <= 94), 32'd1);

    // Test 6: asynchronous reset between edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkVal("asyncRdEn", 32'(romRdEn), 32'd0);
    checkVal("asyncValid", 32'(instrValid), 32'd0);
    checkVal("asyncLevel", 32'(queueLevel), 32'd0);
    checkVal("asyncInstr", instrOut, 32'h0);
    checkVal("asyncPc", 32'(instrPc), 32'h0);
    checkVal("asyncAddr", 32'(romAddress), 32'h000);
`ifdef PREFETCH_STATS_EN
    checkVal("asyncFlushCount", 32'(flushCount), 32'd0);
`endif
    loadExpect(12'h000, 100);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    waitValid("restart", 12'h000);
    repeat (10) @(posedge clk);
    #1 checkVal("restartConsumed", 32'(expQ.size() <= 90), 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
